// File: rtl/step_seq_pkg.sv
// Shared types and defaults for the step sequencer.
// Holds the run/halt state enum and the default index width.
package step_seq_pkg;

    localparam int W_DEFAULT = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/step_sequencer_decoder.sv
// Binary-to-one-hot decoder with an output enable.
// Output is all zero when the enable is low.
module onehot_decoder #(
    parameter int W = 4
) (
    input  logic [W-1:0]      i_idx,
    input  logic              i_en,
    output logic [2**W-1:0]   o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Programmable step sequencer with one-shot halt, jump and clear.
// Emits a binary step index, a gated one-hot strobe and a wrap pulse.
module step_sequencer
    import step_seq_pkg::*;
#(
    parameter int W          = W_DEFAULT,
    parameter int RESET_STEP = 0
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              En,
    input  logic              Clear,
    input  logic              Jump,
    input  logic [W-1:0]      JumpStep,
    input  logic [W-1:0]      Last,
    input  logic              OneShot,
    input  logic              OutEn,
    output logic [W-1:0]      Step,
    output logic [2**W-1:0]   T,
    output logic              Wrap,
    output logic              Halted
);

    localparam logic [W-1:0] L_RESET_STEP = W'(RESET_STEP);

    logic [W-1:0] r_step;
    seq_state_t   r_state;
    logic         r_wrap;
    logic         w_terminal;

    // >= also catches Last lowered below the current step mid-run
    assign w_terminal = (r_step >= Last);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_step  <= L_RESET_STEP;
            r_state <= RUN;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (Clear) begin
                r_step  <= L_RESET_STEP;
                r_state <= RUN;
            end else if (Jump) begin
                r_step  <= JumpStep;
                r_state <= RUN;
            end else if (En && (r_state == RUN)) begin
                if (w_terminal) begin
                    r_wrap <= 1'b1;
                    if (OneShot) begin
                        r_state <= HALT;
                    end else begin
                        r_step <= '0;
                    end
                end else begin
                    r_step <= r_step + 1'b1;
                end
            end
        end
    end

    assign Step   = r_step;
    assign Wrap   = r_wrap;
    assign Halted = (r_state == HALT);

    onehot_decoder #(
        .W (W)
    ) u_dec (
        .i_idx    (r_step),
        .i_en     (OutEn),
        .o_onehot (T)
    );

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: directed scenarios plus
// randomized traffic against a behavioural reference model.
module tb_step_sequencer;

    localparam int W  = 4;
    localparam int RS = 0;

    logic          Clock;
    logic          Resetn;
    logic          En;
    logic          Clear;
    logic          Jump;
    logic [W-1:0]  JumpStep;
    logic [W-1:0]  Last;
    logic          OneShot;
    logic          OutEn;
    logic [W-1:0]  Step;
    logic [15:0]   T;
    logic          Wrap;
    logic          Halted;

    typedef struct {
        int step;
        bit wrap;
        bit halt;
        bit oe;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int   m_step;
    bit   m_halt;

    step_sequencer #(
        .W          (W),
        .RESET_STEP (RS)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .En       (En),
        .Clear    (Clear),
        .Jump     (Jump),
        .JumpStep (JumpStep),
        .Last     (Last),
        .OneShot  (OneShot),
        .OutEn    (OutEn),
        .Step     (Step),
        .T        (T),
        .Wrap     (Wrap),
        .Halted   (Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [15:0] exp_t_vec(input int s, input bit oe);
        logic [15:0] v;
        v = '0;
        if (oe) v[s] = 1'b1;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Monitor: each rising edge that follows a driven cycle
    always @(posedge Clock) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("step", int'(Step), e.step);
            check("wrap", int'(Wrap), int'(e.wrap));
            check("halted", int'(Halted), int'(e.halt));
            check("T", int'(T), int'(exp_t_vec(e.step, e.oe)));
        end
    end

    task automatic cyc(input bit en, input bit clr, input bit jmp,
                       input int js, input int last, input bit os,
                       input bit oe);
        exp_t e;
        @(negedge Clock);
        En       = en;
        Clear    = clr;
        Jump     = jmp;
        JumpStep = W'(js);
        Last     = W'(last);
        OneShot  = os;
        OutEn    = oe;
        e.wrap = 1'b0;
        if (clr) begin
            m_step = RS;
            m_halt = 1'b0;
        end else if (jmp) begin
            m_step = js;
            m_halt = 1'b0;
        end else if (en && !m_halt) begin
            if (m_step < last) begin
                m_step = m_step + 1;
            end else begin
                e.wrap = 1'b1;
                if (os) m_halt = 1'b1;
                else    m_step = 0;
            end
        end
        e.step = m_step;
        e.halt = m_halt;
        e.oe   = oe;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        En     = 1'b0;
        Clear  = 1'b0;
        Jump   = 1'b0;
        Resetn = 1'b0;
        #1;
        check("rst_step", int'(Step), RS);
        check("rst_halted", int'(Halted), 0);
        check("rst_wrap", int'(Wrap), 0);
        check("rst_T", int'(T), int'(exp_t_vec(RS, OutEn)));
        m_step = RS;
        m_halt = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Resetn   = 1'b0;
        En       = 1'b0;
        Clear    = 1'b0;
        Jump     = 1'b0;
        JumpStep = '0;
        Last     = 4'd8;
        OneShot  = 1'b0;
        OutEn    = 1'b1;
        m_step   = RS;
        m_halt   = 1'b0;
        #12;
        do_reset();

        // 0..8 then wrap to 0
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 8, 0, 1);

        // one-shot halt at 3, then jump out to 5
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 3, 1, 1);
        cyc(0, 0, 1, 5, 3, 1, 1);

        // priority Clear > Jump > En
        cyc(0, 0, 1, 4, 15, 0, 1);
        cyc(1, 1, 1, 9, 15, 0, 1);
        cyc(0, 0, 1, 4, 15, 0, 1);
        cyc(1, 0, 1, 9, 15, 0, 1);

        // Last lowered below Step mid-run
        cyc(0, 0, 1, 6, 15, 0, 1);
        cyc(1, 0, 0, 0, 2, 0, 1);
        cyc(0, 0, 1, 6, 15, 1, 1);
        cyc(1, 0, 0, 0, 2, 1, 1);
        cyc(1, 0, 0, 0, 2, 1, 1);

        // OutEn gating at Step 7, then halt and async reset
        cyc(0, 0, 1, 7, 15, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 15, 0, i[0]);
        cyc(1, 0, 0, 0, 7, 1, 1);
        cyc(1, 0, 0, 0, 7, 1, 1);
        @(negedge Clock);
        #2;
        Resetn = 1'b0;
        #1;
        check("async_step", int'(Step), 0);
        check("async_halted", int'(Halted), 0);
        m_step = RS;
        m_halt = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;

        // top-of-range wrap without overflow
        cyc(0, 0, 1, 15, 15, 0, 1);
        cyc(1, 0, 0, 0, 15, 0, 1);

        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 14) == 0,
                int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) != 0);
        end

        @(negedge Clock);
        @(negedge Clock);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter W, default 4, meaning width of the binary step index; the one-hot width is 2**W.
REQ-002 Parameter RESET_STEP, default 0, meaning the step index loaded by reset and by Clear; it SHALL be less than 2**W.
REQ-003 Clock  in  1  rising-edge clock, the only clock of the block.
REQ-004 Resetn  in  1  asynchronous, active-low reset.
REQ-005 En  in  1  advance request, sampled on the rising edge of Clock.
REQ-006 Clear  in  1  synchronous return to RESET_STEP and RUN.
REQ-007 Jump  in  1  synchronous load of JumpStep.
REQ-008 JumpStep  in  W  target step index for Jump.
REQ-009 Last  in  W  programmable terminal step index.
REQ-010 OneShot  in  1  1 = halt at Last; 0 = free-run with wrap to 0.
REQ-011 OutEn  in  1  combinational output gate for T.
REQ-012 Step  out  W  registered binary step index.
REQ-013 T  out  2**W  one-hot step strobe: bit Step set when OutEn=1; all zero when OutEn=0.
REQ-014 Wrap  out  1  registered one-cycle pulse on a terminal transition.
REQ-015 Halted  out  1  registered; 1 while the state is HALT.

Function
REQ-016 States SHALL be RUN and HALT, encoded as an enum from the shared package.
REQ-017 Per-edge priority SHALL be Clear > Jump > En; lower-priority requests in the same cycle SHALL be ignored, not queued.
REQ-018 Clear SHALL set Step=RESET_STEP, state=RUN and Wrap=0 on the next edge.
REQ-019 Jump SHALL set Step=JumpStep and state=RUN on the next edge, including from HALT, with Wrap=0.
REQ-020 In RUN with En=1 and Step<Last, the block SHALL set Step=Step+1 and Wrap=0.
REQ-021 In RUN with En=1, Step>=Last and OneShot=0, the block SHALL set Step=0 and Wrap=1 for exactly one cycle.
REQ-022 In RUN with En=1, Step>=Last and OneShot=1, the block SHALL hold Step, enter HALT, and set Wrap=1 for exactly one cycle.
REQ-023 The >= comparison in REQ-021 and REQ-022 SHALL also cover Last being lowered below the current Step mid-run: the next advance is terminal.
REQ-024 In HALT, En SHALL be ignored and Step held; only Clear, Jump or reset leave HALT.
REQ-025 With En=0 and no Clear or Jump, Step and state SHALL hold, and Wrap SHALL be 0.
REQ-026 Step SHALL never exceed 2**W-1, and incrementing SHALL not overflow because Last<=2**W-1 forces the terminal case at 2**W-1.
REQ-027 T SHALL be decoded from the registered Step, giving one-hot with zero-cycle latency relative to Step; exactly one bit is set when OutEn=1.
REQ-028 OutEn SHALL affect only T, never Step, state, Wrap or Halted.
REQ-029 Latency from a sampled En, Clear or Jump to updated Step/T SHALL be one Clock edge.

Reset
REQ-030 While Resetn=0, asynchronously: Step=RESET_STEP, state=RUN, Wrap=0, Halted=0; T reflects RESET_STEP gated by OutEn.
REQ-031 Reset asserted mid-operation, including in HALT or during a Wrap pulse, SHALL override everything immediately.
REQ-032 The first advance SHALL occur on the first rising edge after Resetn deasserts with En=1.

Structure
REQ-033 Package step_seq_pkg SHALL hold the state enum (RUN, HALT) and the default W constant.
REQ-034 The one-hot decode SHALL be a sub-module onehot_decoder (W-to-2**W, enable input, all-zero when disabled), instantiated once.
REQ-035 All sequential logic SHALL reside in step_sequencer and no other clocks or latches are permitted.

Verification
REQ-036 W=4, Last=8, OneShot=0, En=1 for 12 cycles from reset -> Step 0..8,0,1,2; T=0x0001..0x0100,0x0001; Wrap=1 only on the 8->0 edge.
REQ-037 Last=3, OneShot=1, En held high -> Step 0,1,2,3 then holds 3, Halted=1, single Wrap pulse; a later Jump with JumpStep=5 -> Step=5, Halted=0.
REQ-038 Clear, Jump(JumpStep=9) and En all high at Step=4 -> Step=RESET_STEP; Jump and En both high -> Step=9.
REQ-039 At Step=6, Last changed to 2 with En=1 -> next Step=0, Wrap=1 (OneShot=0); with OneShot=1 -> Step stays 6, HALT.
REQ-040 OutEn toggled at Step=7 -> T alternates 0x0080/0x0000 while Step stays 7; Resetn pulsed low mid-HALT -> Step=0, Halted=0 without a clock edge.
